// File: rtl/icache_port_arbiter_if.sv
// Handshake bundle between the fetch/prefetch requesters, the i-cache port and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface icache_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  logic [ADDR_W-1:0] f_addr_i;
  logic              f_valid_i;
  logic              f_ready_o;
  logic [ADDR_W-1:0] p_addr_i;
  logic              p_valid_i;
  logic              p_ready_o;
  logic [ADDR_W-1:0] addr_o;
  logic              addr_valid_o;
  logic              addr_ready_i;
  logic [LINE_W-1:0] data_i;
  logic              data_valid_i;
  logic              data_ready_o;
  logic [LINE_W-1:0] data_o;
  logic              f_data_valid_o;
  logic              f_data_ready_i;
  logic              p_data_valid_o;
  logic              p_data_ready_i;

  modport slave (
    input  f_addr_i, f_valid_i, p_addr_i, p_valid_i, addr_ready_i,
           data_i, data_valid_i, f_data_ready_i, p_data_ready_i,
    output f_ready_o, p_ready_o, addr_o, addr_valid_o, data_ready_o,
           data_o, f_data_valid_o, p_data_valid_o
  );

  modport master (
    output f_addr_i, f_valid_i, p_addr_i, p_valid_i, addr_ready_i,
           data_i, data_valid_i, f_data_ready_i, p_data_ready_i,
    input  f_ready_o, p_ready_o, addr_o, addr_valid_o, data_ready_o,
           data_o, f_data_valid_o, p_data_valid_o
  );
endinterface

// File: rtl/icache_port_arbiter.sv
// Fetch/prefetch arbiter for the shared i-cache port: one-entry request slot,
// in-order tag FIFO for response routing, flush-driven discard of in-flight lines.
//
//   state   | meaning
//   S_EMPTY | no request held for the i-cache
//   S_PEND  | slot holds {addr, id, discard}; addr_valid_o asserted
module icache_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 128,
  parameter int MAX_OUT    = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  output logic err_o,
  icache_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(MAX_OUT) + 1;
  localparam int IW = PW - 1;
  localparam int SW = $clog2(STARVE_LIM + 1);

  typedef enum logic {S_EMPTY, S_PEND} slot_state_t;

  slot_state_t       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              id_q;       // 1 = prefetcher
  logic              disc_q;
  logic [MAX_OUT-1:0] fifo_id;
  logic [MAX_OUT-1:0] fifo_disc;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [SW-1:0]     starve_q;
  logic              err_q;

  logic [IW-1:0] wr_idx, rd_idx;
  logic [PW-1:0] fifo_cnt;
  logic [PW:0]   cnt_next;
  logic          fifo_empty, fifo_full;
  logic          head_id, head_disc;
  logic          push, pop, accept, f_gnt, p_gnt, p_wins;
  logic          data_ready, f_dv, p_dv;

  assign wr_idx     = wr_ptr[IW-1:0];
  assign rd_idx     = rd_ptr[IW-1:0];
  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_idx == rd_idx) && (wr_ptr[PW-1] != rd_ptr[PW-1]);
  assign head_id    = fifo_id[rd_idx];
  assign head_disc  = fifo_disc[rd_idx];

  always_comb begin
    data_ready = 1'b0;
    f_dv       = 1'b0;
    p_dv       = 1'b0;
    if (!rst_i) begin
      // Empty FIFO, discarded head, or a flush in progress: swallow the line.
      if (fifo_empty || head_disc || flush_i) begin
        data_ready = 1'b1;
      end else if (!head_id) begin
        f_dv       = bus.data_valid_i;
        data_ready = bus.f_data_ready_i;
      end else begin
        p_dv       = bus.data_valid_i;
        data_ready = bus.p_data_ready_i;
      end
    end
    push     = (state_q == S_PEND) && bus.addr_ready_i && !rst_i;
    pop      = bus.data_valid_i && data_ready && !fifo_empty && !rst_i;
    cnt_next = {1'b0, fifo_cnt} + (PW+1)'(push) - (PW+1)'(pop);
    accept   = !rst_i && !flush_i && !fifo_full &&
               ((state_q == S_EMPTY) || push) &&
               (cnt_next < (PW+1)'(MAX_OUT));
    p_wins   = bus.p_valid_i && (!bus.f_valid_i || (starve_q >= SW'(STARVE_LIM)));
    p_gnt    = accept && p_wins;
    f_gnt    = accept && bus.f_valid_i && !p_wins;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_EMPTY;
      addr_q    <= '0;
      id_q      <= 1'b0;
      disc_q    <= 1'b0;
      fifo_id   <= '0;
      fifo_disc <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      starve_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      if (flush_i) fifo_disc <= '1;
      // Later write wins for the pushed slot, so its own discard bit is kept.
      if (push) begin
        fifo_id[wr_idx]   <= id_q;
        fifo_disc[wr_idx] <= disc_q | flush_i;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);

      case (state_q)
        S_EMPTY: begin
          if (f_gnt || p_gnt) begin
            state_q <= S_PEND;
            addr_q  <= p_gnt ? bus.p_addr_i : bus.f_addr_i;
            id_q    <= p_gnt;
            disc_q  <= 1'b0;
          end
        end
        S_PEND: begin
          if (f_gnt || p_gnt) begin
            addr_q <= p_gnt ? bus.p_addr_i : bus.f_addr_i;
            id_q   <= p_gnt;
            disc_q <= 1'b0;
          end else if (push) begin
            state_q <= S_EMPTY;
          end else if (flush_i) begin
            disc_q <= 1'b1;
          end
        end
        default: state_q <= S_EMPTY;
      endcase

      if (flush_i || !bus.p_valid_i || p_gnt)
        starve_q <= '0;
      else if (f_gnt && (starve_q < SW'(STARVE_LIM)))
        starve_q <= starve_q + SW'(1);

      if (bus.data_valid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  assign bus.f_ready_o      = f_gnt;
  assign bus.p_ready_o      = p_gnt;
  assign bus.addr_o         = addr_q;
  assign bus.addr_valid_o   = (state_q == S_PEND) && !rst_i;
  assign bus.data_ready_o   = data_ready;
  assign bus.data_o         = bus.data_i;
  assign bus.f_data_valid_o = f_dv;
  assign bus.p_data_valid_o = p_dv;
  assign err_o              = err_q;
endmodule

// File: doc/icache_port_arbiter.md
Name: icache_port_arbiter

Overview:
- Shares the single i-cache request/response port between two requesters: the fetch stage (demand) and a next-line prefetcher.
- Registers the winning request into a one-entry output slot and tracks outstanding requests in order in a tag FIFO.
- Routes each returning line to the requester that issued it.
- On flush_i, marks every in-flight request as discard, so stale lines are drained without reaching either requester.

Parameters:
- ADDR_W, 32 (XLEN): request address width.
- LINE_W, 128: i-cache line width.
- MAX_OUT, 4: maximum accepted-but-unanswered i-cache requests (power of 2, >=2).
- STARVE_LIM, 8: consecutive cycles the prefetcher loses arbitration before it is forced to win.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  pipeline flush.
- f_addr_i  in  ADDR_W  fetch request address.
- f_valid_i  in  1  fetch request valid.
- f_ready_o  out  1  fetch request accepted.
- p_addr_i  in  ADDR_W  prefetch request address.
- p_valid_i  in  1  prefetch request valid.
- p_ready_o  out  1  prefetch request accepted.
- addr_o  out  ADDR_W  i-cache request address (registered).
- addr_valid_o  out  1  i-cache request valid (registered).
- addr_ready_i  in  1  i-cache accepts request.
- data_i  in  LINE_W  i-cache response line.
- data_valid_i  in  1  i-cache response valid.
- data_ready_o  out  1  response consumed.
- data_o  out  LINE_W  response line to both requesters (= data_i).
- f_data_valid_o  out  1  line valid for fetch.
- f_data_ready_i  in  1  fetch accepts line.
- p_data_valid_o  out  1  line valid for prefetcher.
- p_data_ready_i  in  1  prefetcher accepts line.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (rst_i=1 at a clock edge): output slot empty, addr_valid_o=0, addr_o=0, FIFO empty, starve counter=0, err_o=0. All ready/valid outputs are 0 while rst_i=1.
- Output slot state machine:
  - EMPTY: no pending request.
  - PEND: holds {addr, id, discard}; addr_valid_o=1.
  - addr_o and addr_valid_o come directly from the slot and stay stable while PEND and !addr_ready_i.
- Slot capacity: slot_free = EMPTY, or (PEND and addr_ready_i). No same-cycle bypass from requester to i-cache; request path latency is 1 cycle.
- Accept condition: a new request is accepted only when slot_free, FIFO count after this cycle's push/pop is < MAX_OUT, and flush_i=0.
  - FIFO full blocks acceptance even if a pop occurs the same cycle.
- Arbitration, evaluated only when the accept condition holds:
  - Fetch wins by default.
  - The prefetcher wins if fetch is idle, or if the starve counter is >= STARVE_LIM.
  - Exactly one of f_ready_o / p_ready_o is asserted; the winner is captured into the slot with discard=0.
- Starve counter:
  - Increments (saturating at STARVE_LIM) each cycle p_valid_i=1 and fetch wins.
  - Clears on any prefetch grant, or when p_valid_i=0.
- i-cache handshake (PEND and addr_ready_i): push {id, discard} into the FIFO; the slot goes EMPTY or reloads with the same-cycle winner.
- Response routing, combinational, zero latency, based on the FIFO head:
  - head discard=1: data_ready_o=1, both data_valid outputs 0 (line silently drained).
  - head id=F: f_data_valid_o=data_valid_i; data_ready_o=f_data_ready_i.
  - head id=P: likewise via p_data_valid_o / p_data_ready_i.
  - Pop the FIFO on data_valid_i & data_ready_o.
- Flush (flush_i=1):
  - Sets discard=1 on every FIFO entry and on the PEND slot. The held request is still presented until accepted; it is then pushed as discard.
  - A head response arriving in the flush cycle is drained, not forwarded.
  - No new request is granted in the flush cycle; grants resume the next cycle.
  - The starve counter clears.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged.
  - Flush together with push: the pushed entry is discard=1.
- Protocol error: data_valid_i=1 with an empty FIFO sets err_o=1 (sticky until reset). The line is consumed (data_ready_o=1) and not forwarded.
- Reset mid-operation discards the slot and all FIFO state. Responses arriving after reset for pre-reset requests are treated as protocol errors.
- The FIFO uses wrap-around pointers of $clog2(MAX_OUT)+1 bits; full and empty are derived from the pointer MSB comparison.

Test Plan:
- Only fetch valid, addr 0x100, addr_ready_i=1: addr_valid_o=1 with addr_o=0x100 one cycle after f_ready_o. A response 2 cycles later raises f_data_valid_o=1, with p_data_valid_o=0 throughout.
- Both valid continuously, STARVE_LIM=8, fetch responses returned promptly: prefetch granted once every 9 accepts (8 fetch grants, then 1 prefetch).
- addr_ready_i=1, i-cache never answers: exactly 4 requests accepted, then f_ready_o=0. The first response re-enables acceptance one cycle after the pop.
- 3 outstanding (F,P,F), flush_i pulsed, then 3 responses: data_ready_o=1 for each, no data_valid to either requester. A fresh fetch request issued after the flush gets the next line.
- PEND with addr_ready_i=0 and flush_i=1: addr_valid_o and addr_o hold stable. Once accepted, the response is drained silently.
- data_valid_i=1 with an empty FIFO: err_o rises the next cycle and stays 1 until rst_i.
